// File: rtl/dcs_host_driver.sv
// rtl/dcs_host_driver.sv - host-side job buffer, burst driver and result collector for the DCSformer attention core
//
// Buffers one 136-byte job (8x16 matrix then 8 weights) from an upstream byte
// stream, replays the matrix as a gap-free 128-beat i_valid burst, waits for
// the core's w_ready pulse, replays the weights as an 8-beat w_valid burst,
// captures the eight 32-bit results and presents them downstream in row order.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_valid/s_data/s_ready     upstream job bytes in
//   i_valid/i_data             core matrix beats out
//   w_ready                    core weight-request pulse in
//   w_valid/w_data             core weight beats out
//   o_valid/o_data             core result words in
//   r_valid/r_data/r_last/r_ready  downstream result words out
//   err, err_clr               sticky timeout flag and its synchronous clear
module dcs_host_driver #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        i_valid,
    output logic [7:0]  i_data,
    input  logic        w_ready,
    output logic        w_valid,
    output logic [7:0]  w_data,
    input  logic        o_valid,
    input  logic [31:0] o_data,
    output logic        r_valid,
    output logic [31:0] r_data,
    output logic        r_last,
    input  logic        r_ready,
    output logic        err,
    input  logic        err_clr
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        LOAD,
        STREAM_I,
        WAIT_W,
        STREAM_W,
        COLLECT,
        DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          abort;

    logic          s_ready_q, s_ready_d;
    logic          i_valid_q, i_valid_d;
    logic [7:0]    i_data_q, i_data_d;
    logic          w_valid_q, w_valid_d;
    logic [7:0]    w_data_q, w_data_d;
    logic          r_valid_q, r_valid_d;
    logic [31:0]   r_data_q, r_data_d;
    logic          r_last_q, r_last_d;
    logic          err_q, err_d;

    // Job buffer: matrix at 0..127, weights at 128..135. Result buffer: one word per row.
    logic [7:0]    jobmem_q [0:135];
    logic [31:0]   res_q [0:7];

    logic          job_we;
    logic          res_we;

    // Accept is qualified by the registered s_ready, so nothing is taken in the
    // first cycle after reset while s_ready is still low.
    assign job_we = (state_q == LOAD) && s_valid && s_ready_q;
    assign res_we = (state_q == COLLECT) && o_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        abort   = 1'b0;

        case (state_q)
            LOAD: begin
                if (job_we) begin
                    if (cnt_q == 8'd135) begin
                        state_d = STREAM_I;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            STREAM_I: begin
                if (cnt_q == 8'd127) begin
                    state_d = WAIT_W;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WAIT_W: begin
                // A request arriving on the last allowed cycle still counts as progress.
                if (w_ready) begin
                    state_d = STREAM_W;
                    cnt_d   = 8'd0;
                end else if (tmo_q == TMO_LAST) begin
                    abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            STREAM_W: begin
                if (cnt_q == 8'd7) begin
                    state_d = COLLECT;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            COLLECT: begin
                if (o_valid) begin
                    tmo_d = '0;
                    if (cnt_q == 8'd7) begin
                        state_d = DRAIN;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DRAIN: begin
                if (r_valid_q && r_ready) begin
                    if (cnt_q == 8'd7) begin
                        state_d = LOAD;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = LOAD;
                cnt_d   = 8'd0;
            end
        endcase

        if (abort) begin
            state_d = LOAD;
            cnt_d   = 8'd0;
        end

        if (state_d != state_q) begin
            tmo_d = '0;
        end

        // Outputs are registered images of the next state and next beat index,
        // so each burst starts the cycle after the transition edge.
        s_ready_d = (state_d == LOAD);
        i_valid_d = (state_d == STREAM_I);
        i_data_d  = i_valid_d ? jobmem_q[cnt_d] : 8'd0;
        w_valid_d = (state_d == STREAM_W);
        w_data_d  = w_valid_d ? jobmem_q[cnt_d + 8'd128] : 8'd0;
        r_valid_d = (state_d == DRAIN);
        r_data_d  = r_valid_d ? res_q[cnt_d[2:0]] : 32'd0;
        r_last_d  = r_valid_d && (cnt_d == 8'd7);
        // A timeout in the same cycle as err_clr keeps the flag set.
        err_d     = abort || (err_q && !err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            cnt_q     <= 8'd0;
            tmo_q     <= '0;
            s_ready_q <= 1'b0;
            i_valid_q <= 1'b0;
            i_data_q  <= 8'd0;
            w_valid_q <= 1'b0;
            w_data_q  <= 8'd0;
            r_valid_q <= 1'b0;
            r_data_q  <= 32'd0;
            r_last_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            s_ready_q <= s_ready_d;
            i_valid_q <= i_valid_d;
            i_data_q  <= i_data_d;
            w_valid_q <= w_valid_d;
            w_data_q  <= w_data_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            r_last_q  <= r_last_d;
            err_q     <= err_d;
        end
    end

    // Storage arrays carry no reset; their contents are only read after being written.
    always_ff @(posedge clk) begin
        if (job_we) begin
            jobmem_q[cnt_q] <= s_data;
        end
        if (res_we) begin
            res_q[cnt_q[2:0]] <= o_data;
        end
    end

    assign s_ready = s_ready_q;
    assign i_valid = i_valid_q;
    assign i_data  = i_data_q;
    assign w_valid = w_valid_q;
    assign w_data  = w_data_q;
    assign r_valid = r_valid_q;
    assign r_data  = r_data_q;
    assign r_last  = r_last_q;
    assign err     = err_q;

endmodule

// File: doc/dcs_host_driver.md
# dcs_host_driver

Host-side transmitter/collector for the DCSformer attention core. It buffers one job from an upstream byte stream: a 128-byte 8x16 input matrix followed by an 8-byte weight vector. It then drives the core's i_valid/i_data burst and, after the core's w_ready pulse, the w_valid/w_data burst. It captures the core's eight 32-bit o_data results and hands them downstream on a valid/ready word port.

## Interface
- TIMEOUT, 256: max cycles spent in WAIT_W or COLLECT without progress before abort
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  upstream byte valid
- s_data  in  8  upstream byte: 128 matrix bytes, row-major (row 0 col 0..15, row 1 …), then w[0..7]
- s_ready  out  1  driver accepts s_data
- i_valid  out  1  core input-matrix beat valid
- i_data  out  8  core input-matrix byte
- w_ready  in  1  core weight-request pulse (one cycle)
- w_valid  out  1  core weight beat valid
- w_data  out  8  core weight byte
- o_valid  in  1  core result beat valid
- o_data  in  32  core result word
- r_valid  out  1  downstream result valid
- r_data  out  32  downstream result word, row index 0..7 in order
- r_last  out  1  marks result 7
- r_ready  in  1  downstream accepts result
- err  out  1  sticky timeout flag
- err_clr  in  1  clears err (synchronous)

## Operation
- Storage: 136x8 job buffer (matrix at 0..127, weights at 128..135); 8x32 result buffer; 8-bit beat counter; TIMEOUT counter.
- FSM states: LOAD, STREAM_I, WAIT_W, STREAM_W, COLLECT, DRAIN. Reset state is LOAD.
- LOAD: s_ready=1. Each s_valid&&s_ready writes buf[cnt] and increments cnt. The accept with cnt==135 moves to STREAM_I with cnt=0.
- STREAM_I: i_valid=1, i_data=buf[cnt], for exactly 128 consecutive cycles with no gaps. The core treats any i_valid gap as end-of-matrix. After beat 127, go to WAIT_W.
- WAIT_W: all core outputs idle. When w_ready is sampled high, go to STREAM_W. w_ready seen in any other state is ignored.
- STREAM_W: w_valid=1, w_data=buf[128+k], k=0..7, for 8 consecutive cycles. The first beat comes the cycle after w_ready is sampled, never in the same cycle, because the core clears its accumulators on w_ready. Then go to COLLECT.
- COLLECT: each cycle with o_valid=1 stores res[k]=o_data and increments k. After the 8th capture, go to DRAIN. o_valid outside COLLECT is ignored.
- DRAIN: r_valid=1, r_data=res[k], r_last=(k==7). k advances on r_valid&&r_ready. The handshake at k==7 returns to LOAD with all counters cleared.
- Timeout: the counter resets on state entry and on each captured o_valid beat, and increments otherwise in WAIT_W and COLLECT. When it reaches TIMEOUT-1: set err, drop the partial job (results not presented), and return to LOAD.
- err_clr clears err. If err_clr and a new timeout occur in the same cycle, set wins.
- A new job may be loaded only in LOAD. The ≥8 DRAIN cycles guarantee the core's post-output clear gap before the next i_valid.

## Timing
- Reset value of every output is 0, including s_ready. s_ready rises on the first clock edge after rst_n deasserts.
- All outputs are registered. No combinational path from any input to any output.
- If the 136th byte is accepted at edge t:
  - i_valid is high in cycles t+1..t+128.
  - s_ready is low from t+1.
- If w_ready is sampled high at edge u, w_valid is high in cycles u+1..u+8.
- If the 8th o_valid is captured at edge v, r_valid is high from v+1.
- The r_data/r_last pair holds stable while r_valid && !r_ready.
- After the final r handshake at edge x, s_ready is high from x+1.
- Reset mid-operation: immediately returns to LOAD, all outputs 0, err cleared. Buffer contents need not be cleared.

## Test plan
- Matrix all 1s, weights all 1s, core model → i_valid high exactly 128 cycles, one w_valid burst of 8; r_data = eight results matching the model, r_last only on the 8th.
- Upstream s_valid toggling 50% random → still one gap-free 128-beat i_valid burst; i_data sequence equals the loaded bytes in order.
- w_ready pulse at edge u → w_valid first high at u+1 (not u), w_data = w[0..7] in order.
- r_ready held low 20 cycles, then random → r_data stable while stalled; words 0..7 delivered once each, in order; s_ready reasserts the cycle after the last handshake.
- Core never asserts w_ready (TIMEOUT=16) → err=1 after 16 WAIT_W cycles, s_ready=1; pulse err_clr → err=0; the next job completes normally.
- rst_n asserted mid-STREAM_I → i_valid=0 immediately, s_ready=1 after release; a fresh job completes correctly.
